sram_access_ctrl: RTL and testbench



---
 rtl/sram_access_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: turns a level-style read/write request into a timed,
// multi-cycle SRAM access with one outstanding access at a time.
// Address, write data and operation are latched at acceptance, so the
// upstream requester (or its multiplexer select) may change mid-access
// without disturbing the access in flight.
module sram_access_ctrl #(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 1536,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              write_done,
  output logic              req_conflict,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              is_write_q, is_write_d;
  logic              conflict_q, conflict_d;

  // Next-state logic, request latching, read capture and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    is_write_d   = is_write_q;
    conflict_d   = 1'b0;
    busy         = 1'b0;
    read_valid   = 1'b0;
    write_done   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;

    case (state_q)
      IDLE: begin
        if (read_enable || write_enable) begin
          // Write takes priority when both enables are high.
          addr_d     = address;
          wdata_d    = write_data;
          is_write_d = write_enable;
          conflict_d = read_enable && write_enable;
          cnt_d      = '0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_read  = !is_write_q;
        mem_write = is_write_q;
        if (cnt_q == CNT_LAST) begin
          // SRAM read data is only guaranteed in the last strobe cycle.
          if (!is_write_q) begin
            rdata_d = mem_rdata;
          end
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Inputs are deliberately ignored here to give the requester a
        // cycle to drop its enable before the next acceptance.
        busy       = 1'b1;
        read_valid = !is_write_q;
        write_done = is_write_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers; reset clears everything, including read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
      conflict_q <= conflict_d;
    end
  end

  assign read_data    = rdata_q;
  assign req_conflict = conflict_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed self-checking bench for sram_access_ctrl (ACCESS_CYCLES = 2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sram_access_ctrl;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 1536;
  localparam int AC     = 2;

  logic              clk;
  logic              rst;
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              busy;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              write_done;
  logic              req_conflict;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  sram_access_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read_enable(read_enable),
    .write_enable(write_enable),
    .address(address),
    .write_data(write_data),
    .busy(busy),
    .read_data(read_data),
    .read_valid(read_valid),
    .write_done(write_done),
    .req_conflict(req_conflict),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [ADDR_W-1:0] obs,
                       input logic [ADDR_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed low64 %h, expected low64 %h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] pat_a5;
    logic [DATA_W-1:0] pat_3c;
    logic [DATA_W-1:0] pat_b2b;
    int rv_cnt;
    int rd_cnt;
    int rv_pos;

    ones    = '1;
    pat_a5  = {192{8'hA5}};
    pat_3c  = {192{8'h3C}};
    pat_b2b = {96{16'h5AC3}};

    rst          = 1'b1;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    write_data   = '0;
    mem_rdata    = '0;

    // Reset, then five idle cycles.
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_read_valid", read_valid, 1'b0);
    chk_b("rst_write_done", write_done, 1'b0);
    chk_b("rst_req_conflict", req_conflict, 1'b0);
    chk_b("rst_mem_read", mem_read, 1'b0);
    chk_b("rst_mem_write", mem_write, 1'b0);
    chk_a("rst_mem_addr", mem_addr, '0);
    chk_w("rst_mem_wdata", mem_wdata, '0);
    chk_w("rst_read_data", read_data, '0);

    // Read at 0x000040, all-ones data in the strobe cycles.
    read_enable = 1'b1;
    address     = 24'h000040;
    mem_rdata   = ones;
    step();
    read_enable = 1'b0;
    address     = 24'h0;
    chk_b("rd_c1_mem_read", mem_read, 1'b1);
    chk_b("rd_c1_mem_write", mem_write, 1'b0);
    chk_a("rd_c1_mem_addr", mem_addr, 24'h000040);
    chk_b("rd_c1_busy", busy, 1'b1);
    chk_b("rd_c1_read_valid", read_valid, 1'b0);
    step();
    chk_b("rd_c2_mem_read", mem_read, 1'b1);
    chk_a("rd_c2_mem_addr", mem_addr, 24'h000040);
    chk_b("rd_c2_read_valid", read_valid, 1'b0);
    step();
    mem_rdata = '0;
    chk_b("rd_c3_mem_read", mem_read, 1'b0);
    chk_b("rd_c3_read_valid", read_valid, 1'b1);
    chk_b("rd_c3_busy", busy, 1'b1);
    chk_w("rd_c3_read_data", read_data, ones);
    step();
    chk_b("rd_c4_read_valid", read_valid, 1'b0);
    chk_b("rd_c4_busy", busy, 1'b0);
    chk_w("rd_c4_read_data_hold", read_data, ones);
    step();
    chk_w("rd_c5_read_data_hold", read_data, ones);

    // Write at 0x123456 with inputs changed right after acceptance.
    write_enable = 1'b1;
    address      = 24'h123456;
    write_data   = pat_a5;
    step();
    write_enable = 1'b0;
    address      = '0;
    write_data   = '0;
    chk_b("wr_c1_mem_write", mem_write, 1'b1);
    chk_b("wr_c1_mem_read", mem_read, 1'b0);
    chk_a("wr_c1_mem_addr", mem_addr, 24'h123456);
    chk_w("wr_c1_mem_wdata", mem_wdata, pat_a5);
    chk_b("wr_c1_req_conflict", req_conflict, 1'b0);
    step();
    chk_b("wr_c2_mem_write", mem_write, 1'b1);
    chk_a("wr_c2_mem_addr", mem_addr, 24'h123456);
    chk_w("wr_c2_mem_wdata", mem_wdata, pat_a5);
    step();
    chk_b("wr_c3_mem_write", mem_write, 1'b0);
    chk_b("wr_c3_write_done", write_done, 1'b1);
    chk_b("wr_c3_read_valid", read_valid, 1'b0);
    chk_w("wr_c3_read_data", read_data, ones);
    step();
    chk_b("wr_c4_write_done", write_done, 1'b0);
    chk_b("wr_c4_busy", busy, 1'b0);
    chk_w("wr_c4_read_data", read_data, ones);

    // Both enables high: write wins and conflict pulses once.
    read_enable  = 1'b1;
    write_enable = 1'b1;
    address      = 24'h000001;
    write_data   = pat_3c;
    mem_rdata    = '0;
    step();
    read_enable  = 1'b0;
    write_enable = 1'b0;
    chk_b("cf_c1_req_conflict", req_conflict, 1'b1);
    chk_b("cf_c1_mem_write", mem_write, 1'b1);
    chk_b("cf_c1_mem_read", mem_read, 1'b0);
    chk_a("cf_c1_mem_addr", mem_addr, 24'h000001);
    step();
    chk_b("cf_c2_req_conflict", req_conflict, 1'b0);
    chk_b("cf_c2_mem_write", mem_write, 1'b1);
    chk_b("cf_c2_mem_read", mem_read, 1'b0);
    step();
    chk_b("cf_c3_write_done", write_done, 1'b1);
    chk_b("cf_c3_read_valid", read_valid, 1'b0);
    chk_b("cf_c3_req_conflict", req_conflict, 1'b0);
    chk_w("cf_c3_read_data", read_data, ones);
    step();
    chk_b("cf_c4_busy", busy, 1'b0);

    // read_enable held for 12 cycles: a new read every AC+2 = 4 cycles.
    read_enable = 1'b1;
    address     = 24'h000055;
    mem_rdata   = pat_b2b;
    rv_cnt = 0;
    rd_cnt = 0;
    rv_pos = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (read_valid === 1'b1) begin
        rv_cnt++;
        rv_pos = rv_pos * 16 + i;
      end
      if (mem_read === 1'b1) rd_cnt++;
    end
    read_enable = 1'b0;
    chk_int("b2b_read_valid_count", rv_cnt, 3);
    chk_int("b2b_read_valid_positions", rv_pos, (2 * 256) + (6 * 16) + 10);
    chk_int("b2b_mem_read_cycles", rd_cnt, 6);
    chk_w("b2b_read_data", read_data, pat_b2b);
    step();
    chk_b("b2b_end_busy", busy, 1'b0);

    // Reset during the first strobe cycle of a read.
    read_enable = 1'b1;
    address     = 24'h000077;
    mem_rdata   = ones;
    step();
    read_enable = 1'b0;
    chk_b("rr_c1_mem_read", mem_read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_b("rr_async_mem_read", mem_read, 1'b0);
    chk_b("rr_async_busy", busy, 1'b0);
    chk_w("rr_async_read_data", read_data, '0);
    step();
    chk_b("rr_hold_read_valid", read_valid, 1'b0);
    rst = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (read_valid === 1'b1) rv_cnt++;
    end
    chk_int("rr_no_read_valid", rv_cnt, 0);
    chk_b("rr_idle_busy", busy, 1'b0);
    chk_b("rr_idle_mem_read", mem_read, 1'b0);
    chk_w("rr_idle_read_data", read_data, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
